// File: rtl/wb_data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone data-bus arbiter.
// Optional watchdog feature: WB_ARB_TIMEOUT_EN (adds the DRAIN state).
package wb_data_bus_arbiter_pkg;

    // Master indices, also the bit positions in the grant vector.
    localparam int unsigned ARB_M_INST = 0;
    localparam int unsigned ARB_M_DATA = 1;

    // Default watchdog limit in cycles.
    localparam int unsigned ARB_TIMEOUT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
`ifdef WB_ARB_TIMEOUT_EN
        ,
        DRAIN
`endif
    } arb_state_t;

endpackage

// File: rtl/wb_data_bus_arbiter_watchdog.sv
// Watchdog for the arbiter: counts un-acknowledged strobe cycles and flags
// the cycle in which the limit is reached. Only built with WB_ARB_TIMEOUT_EN.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: cleared while no transfer is granted, stepped on stalled strobes.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_data_bus_arbiter.sv
// Two-master Wishbone classic arbiter: instruction fetch and load/store share
// one slave port. Grant is held for the whole CYC; ties alternate round-robin.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out hung cycles.
module wb_data_bus_arbiter
    import wb_data_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ib_cyc,
    input  logic          ib_stb,
    input  logic          ib_we,
    input  logic [AW-1:0] ib_adr,
    input  logic [DW-1:0] ib_dat_o,
    output logic [DW-1:0] ib_dat_i,
    output logic          ib_ack,
    output logic          ib_err,
    input  logic          db_cyc,
    input  logic          db_stb,
    input  logic          db_we,
    input  logic [AW-1:0] db_adr,
    input  logic [DW-1:0] db_dat_o,
    output logic [DW-1:0] db_dat_i,
    output logic          db_ack,
    output logic          db_err,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    output logic [1:0]    gnt
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("wb_data_bus_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_t state_q, state_d;
    logic       last_gnt_q, last_gnt_d;

    // Currently selected master (0 = instruction, 1 = data) and its request lines.
    logic          sel;
    logic          m_cyc, m_stb;

    assign sel   = (state_q == BUSY_D);
    assign m_cyc = sel ? db_cyc : ib_cyc;
    assign m_stb = sel ? db_stb : ib_stb;

    // Read data goes to both masters; only the ack qualifies it.
    assign ib_dat_i = s_dat_i;
    assign db_dat_i = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_clr, wd_en, wd_expire;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );
`endif

    // Next-state, grant and slave-port mux.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt        = '0;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_adr      = '0;
        s_dat_o    = '0;
        ib_ack     = 1'b0;
        db_ack     = 1'b0;
        ib_err     = 1'b0;
        db_err     = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        wd_clr     = 1'b1;
        wd_en      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ib_cyc && db_cyc) begin
                    if (last_gnt_q == 1'(ARB_M_INST)) begin
                        state_d    = BUSY_D;
                        last_gnt_d = 1'(ARB_M_DATA);
                    end else begin
                        state_d    = BUSY_I;
                        last_gnt_d = 1'(ARB_M_INST);
                    end
                end else if (ib_cyc) begin
                    state_d    = BUSY_I;
                    last_gnt_d = 1'(ARB_M_INST);
                end else if (db_cyc) begin
                    state_d    = BUSY_D;
                    last_gnt_d = 1'(ARB_M_DATA);
                end
            end
            BUSY_I, BUSY_D: begin
                gnt[ARB_M_INST] = ~sel;
                gnt[ARB_M_DATA] = sel;
                s_cyc   = m_cyc;
                s_stb   = m_stb;
                s_we    = sel ? db_we    : ib_we;
                s_adr   = sel ? db_adr   : ib_adr;
                s_dat_o = sel ? db_dat_o : ib_dat_o;
                ib_ack  = s_ack & ~sel;
                db_ack  = s_ack & sel;
                if (!m_cyc) begin
                    state_d = IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                // An ack on the limit cycle keeps wd_en low, so the ack wins.
                wd_clr = 1'b0;
                wd_en  = m_stb & ~s_ack;
                if (wd_expire) begin
                    s_cyc   = 1'b0;
                    s_stb   = 1'b0;
                    ib_err  = ~sel;
                    db_err  = sel;
                    state_d = DRAIN;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            DRAIN: begin
                // last_gnt still names the master whose cycle was terminated.
                if (!(last_gnt_q ? db_cyc : ib_cyc)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'(ARB_M_INST);
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: doc/wb_data_bus_arbiter.md
# wb_data_bus_arbiter

Two-master Wishbone classic arbiter that shares the single core-side Wishbone port between instruction fetch and the load/store (memory access) state machine. It sits between the fetch unit, the load/store sequencer and the memory/peripheral interconnect. It grants one master at a time, holds the grant for the whole CYC, and alternates masters round-robin under contention. An optional watchdog terminates cycles that a slave never acknowledges.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `TIMEOUT`, 256, watchdog limit in cycles; only used with `WB_ARB_TIMEOUT_EN`; must be at least 2.

Ports:
- `clk`  in  1  core clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ib_cyc`, `ib_stb`, `ib_we`  in  1 each  instruction-master cycle, strobe and write enable.
- `ib_adr`  in  AW  instruction-master address.
- `ib_dat_o`  in  DW  instruction-master write data.
- `ib_dat_i`  out  DW  read data to the instruction master.
- `ib_ack`, `ib_err`  out  1 each  acknowledge and error to the instruction master.
- `db_*`  same set as `ib_*`, for the load/store master.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave-side cycle, strobe and write enable.
- `s_adr`  out  AW  slave-side address.
- `s_dat_o`  out  DW  slave-side write data.
- `s_dat_i`  in  DW  slave-side read data.
- `s_ack`  in  1  slave acknowledge.
- `gnt`  out  2  grant vector: [0] instruction, [1] data.

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`, and `DRAIN` (exists only with the macro).
- `IDLE`:
  - Only `ib_cyc` high goes to `BUSY_I`.
  - Only `db_cyc` high goes to `BUSY_D`.
  - Both high: grant the master not in `last_gnt`, then update `last_gnt`.
  - `last_gnt` resets to instruction, so the data master wins the first tie.
- `BUSY_x`:
  - Slave outputs are a combinational pass-through of master x.
  - `s_cyc` = x_cyc and `s_stb` = x_stb.
  - `s_ack` is routed to x_ack only; the other master's ack is 0.
  - When x_cyc is sampled low, go to `IDLE`.
  - The grant is never pre-empted while x_cyc is high, including multi-beat or read-modify-write sequences under one CYC.
- `ib_dat_i` and `db_dat_i` both carry `s_dat_i` unconditionally. Only ack qualifies the data.
- In `IDLE` and `DRAIN`:
  - `s_cyc`, `s_stb`, `s_we` are 0.
  - `s_adr` and `s_dat_o` are 0.
  - Both acks are 0.
- A master that drops CYC for one cycle between two halves of an unaligned access may lose the bus to the other master. This is legal. Each half is an independent cycle.
- `ib_err` and `db_err` are tied 0 without the macro.

## Timing
- Reset values:
  - State `IDLE`, `gnt` = 2'b00.
  - All `s_*` outputs are 0.
  - All acks and errs are 0.
  - `last_gnt` = instruction; watchdog counter = 0.
- Grant latency: a request sampled in `IDLE` at edge N gives `gnt` and `s_cyc` high from cycle N+1. Worst-case single-beat read with a 0-wait slave is 2 cycles from CYC to ACK.
- Release: x_cyc low at edge N gives `IDLE` at N+1. There is exactly one dead cycle between consecutive grants, even to the same master.
- If x_cyc drops in the same cycle as `s_ack`, the ack is still delivered and the state leaves at the next edge.
- `rst_n` asserted mid-cycle immediately forces all outputs to reset values. No ack is delivered for the aborted transfer.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to `BUSY_x` and increments each cycle with `s_stb` high and `s_ack` low.
  - At count `TIMEOUT`-1 without ack, assert x_err for exactly one cycle, force `s_cyc`/`s_stb` to 0 that cycle, and go to `DRAIN`.
  - `DRAIN` holds all `s_*` at 0 until x_cyc is sampled low, then goes to `IDLE`.
  - `s_ack` arriving on the same cycle as the limit wins: normal ack, no err.
- Undefined: no counter, no `DRAIN` state, errs tied 0. The arbiter waits forever.

## Structure
- The shared package holds:
  - the `arb_state_t` enum;
  - the master index constants `ARB_M_INST` = 0 and `ARB_M_DATA` = 1;
  - the default `TIMEOUT`.
- Sub-module `wb_arb_watchdog`: counter plus compare with clr/en/expire ports. It is instantiated under the macro only.
- Slave mux and FSM stay in the top module.

## Test plan
- Only `db_cyc`/`db_stb` with read at 0x100, slave acks 1 cycle later with 0xDEADBEEF: `gnt`=10 at N+1, `db_ack` pulse with `db_dat_i`=0xDEADBEEF, `ib_ack` stays 0.
- Both masters request at the same edge after reset: data granted first. After `db_cyc` drops, one idle cycle, then instruction is granted (`gnt`=01).
- Instruction holds CYC for a 3-beat burst while data requests: `gnt` stays 01 across all 3 acks. Data is granted 2 cycles after `ib_cyc` drops.
- Data does an unaligned pair (CYC low for 1 cycle between halves) while instruction requests continuously: instruction is granted between the halves, and both halves complete with correct addresses 0x203 and 0x207.
- With the macro, `TIMEOUT`=8 and the slave never acks: `db_err` is high in exactly cycle 8 of `BUSY_D`, with `s_cyc` 0 that cycle. The FSM sits in `DRAIN` until `db_cyc` drops, then returns to `IDLE`.
- `rst_n` pulsed low during `BUSY_I` with the slave mid-wait: `s_cyc`, `gnt` and acks are 0 asynchronously, and after release the first tie goes to data.
